platform_sprite_renderer: RTL and testbench

//   Read-side client of the 64x32 12-bit platform sprite ROM (2-cycle latency:

---
 rtl/platform_sprite_renderer.sv | 172 +++++++++++++++++
 tb/tb_platform_sprite_renderer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_sprite_renderer.sv
// -----------------------------------------------------------------------------
// platform_sprite_renderer
//
// Read-side client of the platform sprite ROM. It maps the VGA beam position
// to sprite-local coordinates, drives the ROM address, re-aligns the hit flag
// with the colour the ROM returns two enabled cycles later, and emits an
// opaque-masked pixel to the colour mux.
//
// The platform is SPR_W*TILES pixels wide: the sprite repeats horizontally by
// taking the low log2(SPR_W) bits of the local x offset. The active position
// changes only on frame_start, so a frame is never drawn from two positions.
//
// Optional feature (compile-time macro PLATFORM_SCROLL_EN):
//   defined   - on a frame_start with no pending load, pos_x moves left by
//               SCROLL_STEP and wraps to SCREEN_W once the whole platform has
//               left the screen. SCREEN_W / SCROLL_STEP exist only here.
//   undefined - pos_x changes only through load.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   video_on            beam in visible area; pipeline enable
//   pixel_x, pixel_y    beam position
//   frame_start         1-cycle pulse at start of vertical blank
//   load, load_x/y      1-cycle pulse pending a new position (load_x signed)
//   rom_x, rom_y        ROM coordinates (0 when the beam misses the platform)
//   rom_en              ROM enable (= video_on)
//   rom_color           ROM colour, 2 enabled cycles after the coordinates
//   pix_valid           pix_color is an opaque platform pixel
//   pix_color           pixel colour, 0 when !pix_valid
//
// Output semantics: pix_valid/pix_color form a qualified stream with no
// back-pressure. They are updated only on edges where video_on is high; a
// coordinate presented on enabled edge n appears at the outputs after the
// third enabled edge. While video_on is low every stage holds.
// -----------------------------------------------------------------------------
module platform_sprite_renderer #(
    parameter int          SPR_W       = 64,
    parameter int          SPR_H       = 32,
    parameter int          TILES       = 4,
`ifdef PLATFORM_SCROLL_EN
    parameter int          SCREEN_W    = 640,
    parameter int          SCROLL_STEP = 2,
`endif
    parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       video_on,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       frame_start,
    input  logic                       load,
    input  logic [10:0]                load_x,
    input  logic [9:0]                 load_y,
    output logic [$clog2(SPR_W)-1:0]   rom_x,
    output logic [$clog2(SPR_H)-1:0]   rom_y,
    output logic                       rom_en,
    input  logic [11:0]                rom_color,
    output logic                       pix_valid,
    output logic [11:0]                pix_color
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);

    // Platform extents as signed constants so the range checks below are
    // plain signed comparisons against the signed beam offsets.
    localparam logic signed [11:0] PLAT_W_S = 12'(SPR_W * TILES);
    localparam logic signed [10:0] SPR_H_S  = 11'(SPR_H);

    // Active and pending positions; pos_x is signed so the platform can sit
    // partly or wholly off the left edge.
    logic signed [10:0] pos_x;
    logic signed [10:0] pend_x;
    logic [9:0]         pos_y;
    logic [9:0]         pend_y;
    logic               pend_flag;

`ifdef PLATFORM_SCROLL_EN
    localparam logic signed [11:0] STEP_S   = 12'(SCROLL_STEP);
    localparam logic signed [11:0] WRAP_LIM = -PLAT_W_S;
    localparam logic signed [10:0] WRAP_X   = 11'(SCREEN_W);

    // One bit wider than pos_x so the decrement cannot wrap before the
    // limit comparison sees it.
    logic signed [11:0] scroll_dec;
    logic signed [10:0] scroll_next;

    always_comb begin
        scroll_dec  = {pos_x[10], pos_x} - STEP_S;
        scroll_next = (scroll_dec < WRAP_LIM) ? WRAP_X : scroll_dec[10:0];
    end
`endif

    // Position update. A load coinciding with frame_start takes effect at
    // once and leaves nothing pending; otherwise a load is parked until the
    // next frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= '0;
            pos_y     <= '0;
            pend_x    <= '0;
            pend_y    <= '0;
            pend_flag <= 1'b0;
        end else if (frame_start) begin
            if (load) begin
                pos_x     <= load_x;
                pos_y     <= load_y;
                pend_flag <= 1'b0;
            end else if (pend_flag) begin
                pos_x     <= pend_x;
                pos_y     <= pend_y;
                pend_flag <= 1'b0;
            end
`ifdef PLATFORM_SCROLL_EN
            else begin
                pos_x <= scroll_next;
            end
`endif
        end else if (load) begin
            pend_x    <= load_x;
            pend_y    <= load_y;
            pend_flag <= 1'b1;
        end
    end

    // Beam offsets relative to the platform origin. Widths are chosen so the
    // full input ranges cannot overflow: dx in [-1023, 2047], dy in
    // [-1023, 1023].
    logic signed [11:0] dx;
    logic signed [10:0] dy;
    logic               in_x;
    logic               in_y;
    logic               hit;

    always_comb begin
        dx    = $signed({2'b00, pixel_x}) - $signed({pos_x[10], pos_x});
        dy    = $signed({1'b0, pixel_y}) - $signed({1'b0, pos_y});
        in_x  = (dx >= 12'sd0) && (dx < PLAT_W_S);
        in_y  = (dy >= 11'sd0) && (dy < SPR_H_S);
        hit   = video_on && in_x && in_y;
        // Low bits of dx give the column within the current tile.
        rom_x = hit ? dx[XW-1:0] : '0;
        rom_y = hit ? dy[YW-1:0] : '0;
    end

    assign rom_en = video_on;

    // hit travels alongside the ROM's two internal registers; every stage is
    // enabled by video_on exactly like the ROM, so the flag and the colour
    // stay paired across blanking stalls.
    logic hit_d1;
    logic hit_d2;
    logic opaque;

    assign opaque = hit_d2 && (rom_color != KEY_COLOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_d1    <= 1'b0;
            hit_d2    <= 1'b0;
            pix_valid <= 1'b0;
            pix_color <= '0;
        end else if (video_on) begin
            hit_d1    <= hit;
            hit_d2    <= hit_d1;
            pix_valid <= opaque;
            pix_color <= opaque ? rom_color : 12'h000;
        end
    end

endmodule

// File: tb/tb_platform_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_platform_sprite_renderer
//
// Bench for platform_sprite_renderer. A 2-cycle ROM lives in the bench as
// environment. The reference model tracks the platform position from the
// load/frame_start rules and, per enabled edge, works out the pixel the beam
// sits on directly from the sprite table; a two-entry delay line of enabled
// samples gives the expected outputs. A compare process checks every cycle;
// the directed sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_platform_sprite_renderer;

    localparam logic [11:0] KEY = 12'hF0F;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        video_on    = 1'b0;
    logic [9:0]  pixel_x     = '0;
    logic [9:0]  pixel_y     = '0;
    logic        frame_start = 1'b0;
    logic        load        = 1'b0;
    logic [10:0] load_x      = '0;
    logic [9:0]  load_y      = '0;
    logic [5:0]  rom_x;
    logic [4:0]  rom_y;
    logic        rom_en;
    logic [11:0] rom_color   = '0;
    logic        pix_valid;
    logic [11:0] pix_color;

    platform_sprite_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .load        (load),
        .load_x      (load_x),
        .load_y      (load_y),
        .rom_x       (rom_x),
        .rom_y       (rom_y),
        .rom_en      (rom_en),
        .rom_color   (rom_color),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color)
    );

    // ---------------- sprite ROM (environment) ----------------
    // Word (x,y) = (y*64+x)*7 + 0x123, except (1,10) which is the colour key.
    // No other address of this formula lands on 0xF0F.
    logic [11:0] rom_mem [0:2047];
    logic [10:0] rom_addr_q = '0;

    initial begin
        for (int a = 0; a < 2048; a++) rom_mem[a] = 12'(a * 7 + 12'h123);
        rom_mem[10 * 64 + 1] = KEY;
    end

    always @(posedge clk) begin
        if (rom_en) begin
            rom_addr_q <= {rom_y, rom_x};
            rom_color  <= rom_mem[rom_addr_q];
        end
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pos_x  = 0;
    int m_pos_y  = 0;
    int m_pend_x = 0;
    int m_pend_y = 0;
    bit m_pend   = 1'b0;
    // Each entry is {valid, colour} for one enabled edge still in flight.
    logic [12:0] exp_q[$] = '{13'd0, 13'd0};
    logic        exp_valid = 1'b0;
    logic [11:0] exp_color = '0;

    function automatic bit on_platform(int px, int py, output int lx, output int ly);
        lx = px - m_pos_x;
        ly = py - m_pos_y;
        return (lx >= 0) && (lx < 256) && (ly >= 0) && (ly < 32);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int          lx;
        int          ly;
        logic [11:0] c;
        logic [12:0] s;
        if (!rst_n) begin
            m_pos_x   = 0;
            m_pos_y   = 0;
            m_pend_x  = 0;
            m_pend_y  = 0;
            m_pend    = 1'b0;
            exp_q     = '{13'd0, 13'd0};
            exp_valid = 1'b0;
            exp_color = '0;
        end else begin
            if (video_on) begin
                s = 13'd0;
                if (on_platform(int'(pixel_x), int'(pixel_y), lx, ly)) begin
                    c = rom_mem[(ly % 32) * 64 + (lx % 64)];
                    if (c != KEY) s = {1'b1, c};
                end
                exp_q.push_back(s);
                {exp_valid, exp_color} = exp_q.pop_front();
            end
            if (frame_start) begin
                if (load) begin
                    m_pos_x = int'($signed(load_x));
                    m_pos_y = int'(load_y);
                    m_pend  = 1'b0;
                end else if (m_pend) begin
                    m_pos_x = m_pend_x;
                    m_pos_y = m_pend_y;
                    m_pend  = 1'b0;
                end else begin
`ifdef PLATFORM_SCROLL_EN
                    m_pos_x = m_pos_x - 2;
                    if (m_pos_x < -256) m_pos_x = 640;
`endif
                end
            end else if (load) begin
                m_pend_x = int'($signed(load_x));
                m_pend_y = int'(load_y);
                m_pend   = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int lx;
        int ly;
        int erx;
        int ery;
        if (cmp_en) begin
            erx = 0;
            ery = 0;
            if (video_on && on_platform(int'(pixel_x), int'(pixel_y), lx, ly)) begin
                erx = lx % 64;
                ery = ly % 32;
            end
            check("cyc_rom_x",     32'(rom_x),     32'(erx));
            check("cyc_rom_y",     32'(rom_y),     32'(ery));
            check("cyc_rom_en",    32'(rom_en),    32'(video_on));
            check("cyc_pix_valid", 32'(pix_valid), 32'(exp_valid));
            check("cyc_pix_color", 32'(pix_color), 32'(exp_color));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_beam(int x, int y, logic von);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
    endtask

    task automatic do_load(int x, int y, logic fs);
        load        = 1'b1;
        load_x      = 11'(x);
        load_y      = 10'(y);
        frame_start = fs;
        tick();
        load        = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_pix_color", 32'(pix_color), 32'd0);
        check("reset_rom_x",     32'(rom_x),     32'd0);
        check("reset_rom_y",     32'(rom_y),     32'd0);
        tick();

        // 1: load(100,200) + frame_start, beam on the origin
        do_load(100, 200, 1'b0);
        do_frame();
        set_beam(100, 200, 1'b1);
        @(negedge clk);
        check("t1_rom_x", 32'(rom_x), 32'd0);
        check("t1_rom_y", 32'(rom_y), 32'd0);
        tick(3);
        @(negedge clk);
        check("t1_pix_valid", 32'(pix_valid), 32'd1);
        check("t1_pix_color", 32'(pix_color), 32'h123);
        tick();
        for (int x = 90; x < 370; x++) begin
            set_beam(x, 200, 1'b1);
            tick();
        end

        // 2: just past the right end and just left of the origin
        set_beam(100 + 64 * 4, 200, 1'b1);
        @(negedge clk);
        check("t2_right_rom_x", 32'(rom_x), 32'd0);
        check("t2_right_rom_y", 32'(rom_y), 32'd0);
        tick();
        set_beam(99, 200, 1'b1);
        @(negedge clk);
        check("t2_left_rom_x", 32'(rom_x), 32'd0);
        tick(3);
        @(negedge clk);
        check("t2_pix_valid", 32'(pix_valid), 32'd0);
        tick();

        // 3: second tile, colour-keyed texel
        set_beam(165, 210, 1'b1);
        @(negedge clk);
        check("t3_rom_x", 32'(rom_x), 32'd1);
        check("t3_rom_y", 32'(rom_y), 32'd10);
        tick(3);
        @(negedge clk);
        check("t3_pix_valid", 32'(pix_valid), 32'd0);
        check("t3_pix_color", 32'(pix_color), 32'd0);
        tick();

        // 4: mid-frame load is held; load with frame_start applies at once
        do_load(300, 50, 1'b0);
        set_beam(101, 201, 1'b1);
        @(negedge clk);
        check("t4_held_rom_x", 32'(rom_x), 32'd1);
        check("t4_held_rom_y", 32'(rom_y), 32'd1);
        tick();
        do_frame();
        set_beam(301, 51, 1'b1);
        @(negedge clk);
        check("t4_new_rom_x", 32'(rom_x), 32'd1);
        check("t4_new_rom_y", 32'(rom_y), 32'd1);
        tick();
        set_beam(101, 201, 1'b1);
        @(negedge clk);
        check("t4_old_miss_rom_x", 32'(rom_x), 32'd0);
        tick();
        do_load(20, 30, 1'b1);
        set_beam(21, 31, 1'b1);
        @(negedge clk);
        check("t4_same_rom_x", 32'(rom_x), 32'd1);
        check("t4_same_rom_y", 32'(rom_y), 32'd1);
        tick();
        do_frame();
        set_beam(22, 31, 1'b1);
        @(negedge clk);
`ifdef PLATFORM_SCROLL_EN
        check("t4_nopend_rom_x", 32'(rom_x), 32'd4);
`else
        check("t4_nopend_rom_x", 32'(rom_x), 32'd2);
`endif
        tick();

        // 5: scroll and wrap (or no motion when scrolling is not built)
        do_load(-254, 100, 1'b1);
        set_beam(0, 100, 1'b1);
        @(negedge clk);
        check("t5_start_rom_x", 32'(rom_x), 32'd62);
        tick();
        do_frame();
        set_beam(0, 100, 1'b1);
        @(negedge clk);
`ifdef PLATFORM_SCROLL_EN
        check("t5_step_rom_x", 32'(rom_x), 32'd0);
`else
        check("t5_step_rom_x", 32'(rom_x), 32'd62);
`endif
        tick();
        do_frame();
        set_beam(700, 100, 1'b1);
        @(negedge clk);
`ifdef PLATFORM_SCROLL_EN
        check("t5_wrap_rom_x", 32'(rom_x), 32'd60);
`else
        check("t5_wrap_rom_x", 32'(rom_x), 32'd0);
`endif
        tick();

        // 6: video_on low for 5 cycles in the middle of a hit run
        do_load(100, 200, 1'b1);
        for (int x = 100; x < 104; x++) begin
            set_beam(x, 200, 1'b1);
            tick();
        end
        set_beam(104, 200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_hold_valid", 32'(pix_valid), 32'd1);
            check("t6_hold_color", 32'(pix_color), 32'h12A);
            tick();
        end
        set_beam(104, 200, 1'b1);
        tick();
        @(negedge clk);
        check("t6_resume_color", 32'(pix_color), 32'h131);
        tick();
        for (int x = 105; x < 121; x++) begin
            set_beam(x, 200, 1'b1);
            tick();
        end

        // Reset mid-line, then pipeline refill
        set_beam(5, 5, 1'b1);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(pix_valid), 32'd0);
        check("rst_mid_color", 32'(pix_color), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("refill_1_valid", 32'(pix_valid), 32'd0);
        tick();
        @(negedge clk);
        check("refill_2_valid", 32'(pix_valid), 32'd0);
        tick();
        @(negedge clk);
        check("refill_3_valid", 32'(pix_valid), 32'd1);
        check("refill_3_color", 32'(pix_color), 32'hA06);
        tick(2);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
